video_line_fetch_sched: RTL and testbench

- Bus-clock scheduler that sequences the framebuffer-to-line-buffer data mover for the video unit.
- On each frame start it latches a shadow copy of framebuffer geometry, then prefetches line 0.
- On each displayed-line start it issues the fetch for the next line into the alternate half of the double-banked line buffer.
- Tracks per-bank readiness and flags underruns when the display outpaces DMA.

---
 rtl/video_line_fetch_sched.sv | 161 ++++++++++++++++
 tb/tb_video_line_fetch_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_line_fetch_sched.sv
// Line-fetch scheduler: turns frame/line start pulses into data-mover transfers that fill
// alternate banks of a double-banked line buffer, tracking bank readiness and underruns.
module video_line_fetch_sched #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned BANK_BYTES = 16384
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [ADDR_WIDTH-1:0] fb_base_i,
  input  logic [13:0]           fb_bpl_i,
  input  logic [11:0]           fb_width_i,
  input  logic [11:0]           fb_height_i,
  input  logic                  fb_depth_i,
  input  logic                  frame_start_i,
  input  logic                  line_start_i,
  output logic [ADDR_WIDTH-1:0] dma_src_addr_o,
  output logic [ADDR_WIDTH-1:0] dma_dest_addr_o,
  output logic [ADDR_WIDTH-1:0] dma_length_o,
  output logic                  dma_en_o,
  input  logic                  dma_done_i,
  output logic [1:0]            bank_ready_o,
  output logic                  busy_o,
  output logic [11:0]           cur_line_o,
  output logic                  underrun_o,
  input  logic                  underrun_clr_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                r_state, w_state_next;
  logic [13:0]           r_sh_bpl;
  logic [11:0]           r_sh_width, r_sh_height;
  logic                  r_sh_depth;
  logic [11:0]           r_req_line;
  logic [ADDR_WIDTH-1:0] r_req_src;
  logic                  r_pend;
  logic [11:0]           r_pend_line;
  logic [ADDR_WIDTH-1:0] r_pend_src;
  logic [14:0]           r_pend_len;
  logic [ADDR_WIDTH-1:0] r_dma_src;
  logic [14:0]           r_dma_len;
  logic [11:0]           r_cur_line;
  logic [1:0]            r_bank_ready;
  logic                  r_keep;
  logic                  r_underrun;

  logic                  w_frame_req, w_line_req, w_req, w_take, w_done, w_busy;
  logic [12:0]           w_line_inc;
  logic [11:0]           w_req_line, w_width;
  logic [ADDR_WIDTH-1:0] w_req_src;
  logic                  w_depth;
  logic [13:0]           w_bytes;
  logic [14:0]           w_len_sum, w_req_len;

  // The line index and source address advance per accepted line request, so a request that
  // overwrites an unissued one still lands on the correct framebuffer row.
  always_comb begin
    w_frame_req = frame_start_i & enable_i;
    w_line_inc  = {1'b0, r_req_line} + 13'd1;
    w_line_req  = line_start_i & enable_i & ~w_frame_req & (w_line_inc < {1'b0, r_sh_height});
    w_req       = w_frame_req | w_line_req;
    w_req_line  = w_frame_req ? 12'd0 : w_line_inc[11:0];
    w_req_src   = w_frame_req ? fb_base_i : r_req_src + ADDR_WIDTH'(r_sh_bpl);
    w_width     = w_frame_req ? fb_width_i : r_sh_width;
    w_depth     = w_frame_req ? fb_depth_i : r_sh_depth;
    w_bytes     = w_depth ? {1'b0, w_width, 1'b0} : {w_width, 2'b00};
    w_len_sum   = {1'b0, w_bytes} + 15'd7;
    w_req_len   = {w_len_sum[14:3], 3'b000};
    w_busy      = (r_state != StIdle);
    w_take      = (r_state == StIdle) & r_pend & enable_i;
    w_done      = (r_state == StWait) & dma_done_i;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_take) w_state_next = StIssue;
      StIssue: w_state_next = StWait;
      StWait:  if (dma_done_i) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_sh_bpl     <= '0;
      r_sh_width   <= '0;
      r_sh_height  <= '0;
      r_sh_depth   <= 1'b0;
      r_req_line   <= '0;
      r_req_src    <= '0;
      r_pend       <= 1'b0;
      r_pend_line  <= '0;
      r_pend_src   <= '0;
      r_pend_len   <= '0;
      r_dma_src    <= '0;
      r_dma_len    <= '0;
      r_cur_line   <= '0;
      r_bank_ready <= '0;
      r_keep       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_frame_req) begin
        r_sh_bpl    <= fb_bpl_i;
        r_sh_width  <= fb_width_i;
        r_sh_height <= fb_height_i;
        r_sh_depth  <= fb_depth_i;
      end
      if (w_req) begin
        r_req_line <= w_req_line;
        r_req_src  <= w_req_src;
      end
      if (w_take) begin
        r_dma_src                   <= r_pend_src;
        r_dma_len                   <= r_pend_len;
        r_cur_line                  <= r_pend_line;
        r_keep                      <= 1'b1;
        r_pend                      <= 1'b0;
        r_bank_ready[r_pend_line[0]] <= 1'b0;
      end
      if (w_done && r_keep && enable_i) begin
        r_bank_ready[r_cur_line[0]] <= 1'b1;
      end
      // A zero-length line needs no transfer; its bank is ready immediately.
      if (w_req) begin
        if (w_req_len == 15'd0) begin
          r_pend                      <= 1'b0;
          r_bank_ready[w_req_line[0]] <= 1'b1;
        end else begin
          r_pend      <= 1'b1;
          r_pend_line <= w_req_line;
          r_pend_src  <= w_req_src;
          r_pend_len  <= w_req_len;
        end
      end
      if (w_req && (w_busy || r_pend)) begin
        r_underrun <= 1'b1;
      end else if (underrun_clr_i) begin
        r_underrun <= 1'b0;
      end
      if (!enable_i) begin
        r_pend       <= 1'b0;
        r_bank_ready <= '0;
        r_keep       <= 1'b0;
      end
    end
  end

  assign dma_src_addr_o  = r_dma_src;
  assign dma_dest_addr_o = r_cur_line[0] ? ADDR_WIDTH'(BANK_BYTES) : '0;
  assign dma_length_o    = ADDR_WIDTH'(r_dma_len);
  assign dma_en_o        = (r_state == StIssue);
  assign bank_ready_o    = r_bank_ready;
  assign busy_o          = w_busy;
  assign cur_line_o      = r_cur_line;
  assign underrun_o      = r_underrun;

endmodule

// File: tb/tb_video_line_fetch_sched.sv
// Bench for video_line_fetch_sched: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model that derives addresses as base + line*bpl.
module tb_video_line_fetch_sched;

  logic        clk = 1'b0;
  logic        rst, en, frame, line, done, clr, depth;
  logic [63:0] base;
  logic [13:0] bpl;
  logic [11:0] width, height;
  logic [63:0] dma_src, dma_dest, dma_len;
  logic        dma_en, busy, underrun;
  logic [1:0]  bank_ready;
  logic [11:0] cur_line;

  always #5 clk = ~clk;

  video_line_fetch_sched #(.ADDR_WIDTH(64), .BANK_BYTES(16384)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (en),
    .fb_base_i      (base),
    .fb_bpl_i       (bpl),
    .fb_width_i     (width),
    .fb_height_i    (height),
    .fb_depth_i     (depth),
    .frame_start_i  (frame),
    .line_start_i   (line),
    .dma_src_addr_o (dma_src),
    .dma_dest_addr_o(dma_dest),
    .dma_length_o   (dma_len),
    .dma_en_o       (dma_en),
    .dma_done_i     (done),
    .bank_ready_o   (bank_ready),
    .busy_o         (busy),
    .cur_line_o     (cur_line),
    .underrun_o     (underrun),
    .underrun_clr_i (clr)
  );

  int vectors = 0;
  int miscompares = 0;
  bit auto_done;
  int dly, wcnt;

  // Model: phase 0 = no transfer, 1 = start pulse, 2 = awaiting completion.
  int              m_phase, m_cur, m_req_line, m_pend_line, m_bpl, m_w, m_h;
  bit              m_pend, m_keep, m_under, m_d;
  bit [1:0]        m_rdy;
  longint unsigned m_base, m_src, m_len, m_pend_src, m_pend_len;

  function automatic longint unsigned line_bytes(int w, bit d);
    return ((longint'(w) * (d ? 2 : 4) + 7) / 8) * 8;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int ph, l;
    bit pd, fr, ln, req;
    longint unsigned s, nb;
    if (rst) begin
      m_phase = 0; m_cur = 0; m_req_line = 0; m_pend_line = 0; m_bpl = 0; m_w = 0; m_h = 0;
      m_pend = 0; m_keep = 0; m_under = 0; m_d = 0; m_rdy = 0;
      m_base = 0; m_src = 0; m_len = 0; m_pend_src = 0; m_pend_len = 0;
      return;
    end
    ph = m_phase;
    pd = m_pend;
    fr = frame && en;
    ln = line && en && !fr && (m_req_line + 1 < m_h);
    req = fr || ln;
    if (ph == 2 && done) begin
      if (m_keep && en) m_rdy[m_cur % 2] = 1'b1;
      m_phase = 0;
    end else if (ph == 1) begin
      m_phase = 2;
    end else if (ph == 0 && pd && en) begin
      m_phase = 1;
      m_cur = m_pend_line;
      m_src = m_pend_src;
      m_len = m_pend_len;
      m_rdy[m_cur % 2] = 1'b0;
      m_keep = 1;
      m_pend = 0;
    end
    if (fr) begin
      m_base = base; m_bpl = int'(bpl); m_w = int'(width); m_h = int'(height); m_d = depth;
      m_req_line = 0;
    end else if (ln) begin
      m_req_line++;
    end
    if (req && (ph != 0 || pd)) m_under = 1;
    else if (clr) m_under = 0;
    if (req) begin
      l  = m_req_line;
      nb = line_bytes(m_w, m_d);
      s  = m_base + 64'(l) * 64'(m_bpl);
      if (nb == 0) begin
        m_rdy[l % 2] = 1'b1;
        m_pend = 0;
      end else begin
        m_pend = 1; m_pend_line = l; m_pend_src = s; m_pend_len = nb;
      end
    end
    if (!en) begin
      m_pend = 0; m_rdy = 0; m_keep = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("dma_en", {63'd0, dma_en}, {63'd0, m_phase == 1});
    chk("busy", {63'd0, busy}, {63'd0, m_phase != 0});
    chk("bank_ready", {62'd0, bank_ready}, {62'd0, m_rdy});
    chk("underrun", {63'd0, underrun}, {63'd0, m_under});
    if (m_phase != 0) begin
      chk("cur_line", {52'd0, cur_line}, 64'(m_cur));
      chk("dma_src", dma_src, m_src);
      chk("dma_dest", dma_dest, 64'((m_cur % 2) * 16384));
      chk("dma_len", dma_len, m_len);
    end
    frame = 0; line = 0; clr = 0;
    if (auto_done) begin
      if (m_phase == 2) begin
        wcnt++;
        done = (wcnt >= dly);
      end else begin
        wcnt = 0;
        done = 0;
      end
    end
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    while ((m_phase != 0 || m_pend) && n < bound) begin
      step();
      n++;
    end
    if (m_phase != 0 || m_pend) begin
      miscompares++;
      $display("FAIL wait_idle: still busy after %0d cycles", bound);
    end
  endtask

  task automatic wait_en(int bound);
    int n = 0;
    while (!dma_en && n < bound) begin
      step();
      n++;
    end
    if (!dma_en) begin
      miscompares++;
      $display("FAIL wait_en: no start pulse within %0d cycles", bound);
    end
  endtask

  initial begin
    rst = 1; en = 0; frame = 0; line = 0; done = 0; clr = 0;
    base = 0; bpl = 0; width = 0; height = 0; depth = 0;
    auto_done = 1; dly = 10; wcnt = 0;
    step(); step();
    chk("reset_bank_ready", {62'd0, bank_ready}, 64'd0);
    chk("reset_cur_line", {52'd0, cur_line}, 64'd0);
    chk("reset_src", dma_src, 64'd0);
    rst = 0; en = 1;

    // Frame setup and line-0 prefetch.
    base = 64'h8000_0000; bpl = 14'd2048; width = 12'd640; height = 12'd480; depth = 0;
    frame = 1; step(); step();
    chk("setup_en", {63'd0, dma_en}, 64'd1);
    chk("setup_src", dma_src, 64'h8000_0000);
    chk("setup_dest", dma_dest, 64'd0);
    chk("setup_len", dma_len, 64'd2560);
    wait_idle(50);
    chk("setup_ready", {62'd0, bank_ready}, 64'd1);

    for (int n = 0; n < 3; n++) begin
      line = 1; step(); step();
      chk("line_en", {63'd0, dma_en}, 64'd1);
      chk("line_src", dma_src, 64'h8000_0800 + 64'(n) * 64'h800);
      chk("line_dest", dma_dest, (n % 2 == 0) ? 64'd16384 : 64'd0);
      wait_idle(50);
    end
    chk("no_underrun", {63'd0, underrun}, 64'd0);

    // 16 bpp with odd width rounds up; zero width marks the bank ready without a transfer.
    depth = 1; width = 12'd637; frame = 1; step(); step();
    chk("len_16bpp", dma_len, 64'd1280);
    wait_idle(50);
    en = 0; step(); en = 1; step();
    chk("en_drop_clear", {62'd0, bank_ready}, 64'd0);
    width = 0; frame = 1; step();
    chk("zero_w_ready", {62'd0, bank_ready}, 64'd1);
    step(); step();
    chk("zero_w_no_en", {63'd0, dma_en}, 64'd0);

    // Two line starts while a transfer is held: underrun, only the later line issues.
    width = 12'd640; depth = 0; frame = 1; step();
    wait_idle(50);
    auto_done = 0; done = 0;
    line = 1; step(); step(); step();
    line = 1; step();
    line = 1; step();
    chk("underrun_set", {63'd0, underrun}, 64'd1);
    step(); step();
    auto_done = 1; dly = 1;
    step(); step();
    wait_en(20);
    chk("overwrite_src", dma_src, 64'h8000_1800);
    chk("overwrite_line", {52'd0, cur_line}, 64'd3);
    wait_idle(50);
    clr = 1; step();
    chk("underrun_clr", {63'd0, underrun}, 64'd0);

    // Run to the last line; a base change mid-frame must not take effect until the next frame.
    dly = 2;
    while (m_req_line + 1 < 480) begin
      if (m_req_line == 100) base = 64'h9000_0000;
      line = 1; step();
      wait_idle(30);
    end
    chk("last_line", {52'd0, cur_line}, 64'd479);
    line = 1; step(); step(); step();
    chk("past_end_busy", {63'd0, busy}, 64'd0);
    frame = 1; step(); step();
    chk("new_base_src", dma_src, 64'h9000_0000);

    // Reset during the wait phase abandons the transfer.
    auto_done = 0; done = 0;
    step();
    rst = 1; step(); rst = 0;
    done = 1; step(); done = 0; step();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {62'd0, bank_ready}, 64'd0);
    chk("rst_line", {52'd0, cur_line}, 64'd0);

    // Enable drop mid-transfer: completes without readiness, later lines ignored.
    frame = 1; step(); step(); step();
    en = 0; step();
    done = 1; step(); done = 0; step();
    chk("en_off_ready", {62'd0, bank_ready}, 64'd0);
    chk("en_off_busy", {63'd0, busy}, 64'd0);
    line = 1; step(); step(); step();
    chk("en_off_no_fetch", {63'd0, dma_en}, 64'd0);
    en = 1;

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom % 600 == 0);
      if ($urandom % 120 == 0) en = ~en;
      frame = ($urandom % 50 == 0);
      line  = ($urandom % 6 == 0);
      done  = ($urandom % 5 == 0);
      clr   = ($urandom % 25 == 0);
      if ($urandom % 8 == 0) begin
        base   = {$urandom, $urandom} & ~64'h7;
        bpl    = 14'($urandom % 2048) << 3;
        width  = ($urandom % 5 == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
        height = 12'($urandom_range(0, 6));
        depth  = 1'($urandom % 2);
      end
      step();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
